alu_rr_scheduler: RTL and testbench

// - Shares one combinational ALU core (ADD/SUB/AND/OR/SNE/PASSB, carry/zero/sign flags) among NUM_REQ requesters.
// - Round-robin arbitration with a valid/ready handshake on each request port.
// - Captures the winner's opcode and operands, executes, registers result+flags, returns them tagged with requester ID.
// - Sits between the issue logic of several datapath clients and the single ALU instance.

---
 rtl/alu_sched_pkg.sv | 21 ++
 rtl/alu_core.sv | 47 ++++
 rtl/alu_rr_scheduler.sv | 141 ++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes, FSM states
// and the width of the registered flag bundle.
package alu_sched_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_SNE   = 4'd4;
    localparam logic [3:0] OP_PASSB = 4'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    // Flag bundle layout: {carry, zero, sign}
    localparam int FLAG_W = 3;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU shared by all requesters of the scheduler.
// Unknown opcodes produce a zero result with carry cleared.
module alu_core
    import alu_sched_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] input1_i,
    input  logic [WIDTH-1:0] input2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             sign_o
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, input1_i} + {1'b0, input2_i};

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (opcode_i)
            OP_ADD: begin
                result_o = sum[WIDTH-1:0];
                carry_o  = sum[WIDTH];
            end
            OP_SUB: begin
                result_o = input1_i - input2_i;
                carry_o  = (input1_i < input2_i);
            end
            OP_AND:   result_o = input1_i & input2_i;
            OP_OR:    result_o = input1_i | input2_i;
            OP_SNE:   result_o = {{(WIDTH-1){1'b0}}, (input1_i != input2_i)};
            OP_PASSB: result_o = input2_i;
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

    assign zero_o = (result_o == '0);
    assign sign_o = result_o[WIDTH-1];

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin arbiter in front of a single shared ALU: grant, capture,
// execute, then hold the tagged response until the consumer accepts it.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int WIDTH   = 128,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       reqValid,
    output logic [NUM_REQ-1:0]       reqReady,
    input  logic [4*NUM_REQ-1:0]     reqOpcode,
    input  logic [WIDTH*NUM_REQ-1:0] reqInput1,
    input  logic [WIDTH*NUM_REQ-1:0] reqInput2,
    output logic                     rspValid,
    input  logic                     rspReady,
    output logic [ID_W-1:0]          rspId,
    output logic [WIDTH-1:0]         rspResult,
    output logic                     rspCarry,
    output logic                     rspZero,
    output logic                     rspSign,
    output logic                     busy
);

    sched_state_e      state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   gnt_q;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  res_q;
    logic [FLAG_W-1:0] flags_q;
    logic              rsp_valid_q;

    logic              arb_any_d;
    logic [ID_W-1:0]   arb_gnt_d;
    logic [3:0]        sel_op_d;
    logic [WIDTH-1:0]  sel_a_d;
    logic [WIDTH-1:0]  sel_b_d;

    logic [WIDTH-1:0]  core_res;
    logic              core_carry;
    logic              core_zero;
    logic              core_sign;

    // First pass searches from the pointer upward; second pass wraps to index 0.
    always_comb begin
        arb_any_d = 1'b0;
        arb_gnt_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!arb_any_d && reqValid[i] && (ID_W'(i) >= rr_ptr_q)) begin
                arb_any_d = 1'b1;
                arb_gnt_d = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!arb_any_d && reqValid[i]) begin
                arb_any_d = 1'b1;
                arb_gnt_d = ID_W'(i);
            end
        end
    end

    always_comb begin
        sel_op_d = '0;
        sel_a_d  = '0;
        sel_b_d  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            reqReady[i] = (state_q == IDLE) && arb_any_d && (arb_gnt_d == ID_W'(i));
            if (arb_gnt_d == ID_W'(i)) begin
                sel_op_d = reqOpcode[4*i +: 4];
                sel_a_d  = reqInput1[WIDTH*i +: WIDTH];
                sel_b_d  = reqInput2[WIDTH*i +: WIDTH];
            end
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .opcode_i (op_q),
        .input1_i (a_q),
        .input2_i (b_q),
        .result_o (core_res),
        .carry_o  (core_carry),
        .zero_o   (core_zero),
        .sign_o   (core_sign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            flags_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_any_d) begin
                        gnt_q   <= arb_gnt_d;
                        op_q    <= sel_op_d;
                        a_q     <= sel_a_d;
                        b_q     <= sel_b_d;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_q       <= core_res;
                    flags_q     <= {core_carry, core_zero, core_sign};
                    rr_ptr_q    <= (gnt_q == ID_W'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rspReady) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rspValid  = rsp_valid_q;
    assign rspId     = gnt_q;
    assign rspResult = res_q;
    assign rspCarry  = flags_q[2];
    assign rspZero   = flags_q[1];
    assign rspSign   = flags_q[0];
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler at WIDTH=8, NUM_REQ=4.
module tb_alu_rr_scheduler;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       reqValid;
    logic [NUM_REQ-1:0]       reqReady;
    logic [4*NUM_REQ-1:0]     reqOpcode;
    logic [WIDTH*NUM_REQ-1:0] reqInput1;
    logic [WIDTH*NUM_REQ-1:0] reqInput2;
    logic                     rspValid;
    logic                     rspReady;
    logic [ID_W-1:0]          rspId;
    logic [WIDTH-1:0]         rspResult;
    logic                     rspCarry;
    logic                     rspZero;
    logic                     rspSign;
    logic                     busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_rr_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqOpcode (reqOpcode),
        .reqInput1 (reqInput1),
        .reqInput2 (reqInput2),
        .rspValid  (rspValid),
        .rspReady  (rspReady),
        .rspId     (rspId),
        .rspResult (rspResult),
        .rspCarry  (rspCarry),
        .rspZero   (rspZero),
        .rspSign   (rspSign),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [7:0] res, input logic c,
                           input logic z, input logic s, input logic [1:0] id);
        chk({tag, ".valid"},  32'(rspValid),  32'd1);
        chk({tag, ".result"}, 32'(rspResult), 32'(res));
        chk({tag, ".carry"},  32'(rspCarry),  32'(c));
        chk({tag, ".zero"},   32'(rspZero),   32'(z));
        chk({tag, ".sign"},   32'(rspSign),   32'(s));
        chk({tag, ".id"},     32'(rspId),     32'(id));
    endtask

    // Single-requester transaction; returns with the DUT in RESP.
    task automatic issue(input int id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        reqOpcode[4*id +: 4]         = op;
        reqInput1[WIDTH*id +: WIDTH] = a;
        reqInput2[WIDTH*id +: WIDTH] = b;
        reqValid                     = 4'(1 << id);
        tick();
        reqValid = '0;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        reqValid  = '0;
        reqOpcode = '0;
        reqInput1 = '0;
        reqInput2 = '0;
        rspReady  = 1'b0;
        tick();
        tick();
        chk("reset.rspValid", 32'(rspValid), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.reqReady", 32'(reqReady), 32'd0);
        chk("reset.rspResult", 32'(rspResult), 32'd0);
        chk("reset.rspId", 32'(rspId), 32'd0);

        // req0 ADD FF+01
        rst            = 1'b0;
        rspReady       = 1'b1;
        reqOpcode[3:0] = 4'd0;
        reqInput1[7:0] = 8'hFF;
        reqInput2[7:0] = 8'h01;
        reqValid       = 4'b0001;
        #1;
        chk("add.reqReady", 32'(reqReady), 32'h1);
        tick();
        reqValid = '0;
        chk("add.exec.rspValid", 32'(rspValid), 32'd0);
        chk("add.exec.busy", 32'(busy), 32'd1);
        chk("add.exec.reqReady", 32'(reqReady), 32'd0);
        tick();
        chk_rsp("add", 8'h00, 1'b1, 1'b1, 1'b0, 2'd0);
        tick();
        chk("add.done.rspValid", 32'(rspValid), 32'd0);
        chk("add.done.busy", 32'(busy), 32'd0);

        // req2 SUB 03-05, pointer now at 1
        reqOpcode[11:8]  = 4'd1;
        reqInput1[23:16] = 8'h03;
        reqInput2[23:16] = 8'h05;
        reqValid         = 4'b0100;
        #1;
        chk("sub.reqReady", 32'(reqReady), 32'h4);
        tick();
        reqValid = '0;
        tick();
        chk_rsp("sub", 8'hFE, 1'b1, 1'b0, 1'b1, 2'd2);
        tick();

        // Round robin with all requesters valid, starting from pointer 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            reqOpcode[4*i +: 4]         = 4'd0;
            reqInput1[WIDTH*i +: WIDTH] = 8'(i);
            reqInput2[WIDTH*i +: WIDTH] = 8'h10;
        end
        reqValid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int exp_id;
            exp_id = n % NUM_REQ;
            #1;
            chk($sformatf("rr%0d.reqReady", n), 32'(reqReady), 32'(1 << exp_id));
            tick();
            chk($sformatf("rr%0d.exec.reqReady", n), 32'(reqReady), 32'd0);
            tick();
            chk_rsp($sformatf("rr%0d", n), 8'(8'h10 + exp_id), 1'b0, 1'b0, 1'b0, 2'(exp_id));
            chk($sformatf("rr%0d.resp.reqReady", n), 32'(reqReady), 32'd0);
            tick();
        end
        reqValid = '0;

        // Backpressure: req1 PASSB 80 held in RESP for 5 cycles, pointer now at 1
        rspReady = 1'b0;
        issue(1, 4'd5, 8'h33, 8'h80);
        reqValid = 4'b1000;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk_rsp($sformatf("stall%0d", n), 8'h80, 1'b0, 1'b0, 1'b1, 2'd1);
            chk($sformatf("stall%0d.reqReady", n), 32'(reqReady), 32'd0);
            tick();
        end
        rspReady = 1'b1;
        tick();
        chk("release.rspValid", 32'(rspValid), 32'd0);
        chk("release.busy", 32'(busy), 32'd0);
        chk("release.reqReady", 32'(reqReady), 32'h8);

        // Reset while EXEC: pointer at 2, so req2 wins first
        reqValid = 4'b1111;
        #1;
        chk("rstexec.reqReady", 32'(reqReady), 32'h4);
        tick();
        chk("rstexec.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstexec.rspValid", 32'(rspValid), 32'd0);
        chk("rstexec.busy.after", 32'(busy), 32'd0);
        chk("rstexec.rspResult", 32'(rspResult), 32'd0);
        #1;
        chk("rstexec.regrant", 32'(reqReady), 32'h1);
        reqValid = '0;
        tick();
        chk("rstexec.rspValid.1", 32'(rspValid), 32'd0);
        tick();
        chk("rstexec.rspValid.2", 32'(rspValid), 32'd0);

        // Opcode sweep on requester 0
        issue(0, 4'd4, 8'h12, 8'h12);
        chk_rsp("sne_eq", 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
        tick();
        issue(0, 4'd4, 8'h12, 8'h13);
        chk_rsp("sne_ne", 8'h01, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        issue(0, 4'd5, 8'h00, 8'h80);
        chk_rsp("passb", 8'h80, 1'b0, 1'b0, 1'b1, 2'd0);
        tick();
        issue(0, 4'd7, 8'hFF, 8'hFF);
        chk_rsp("op7", 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
        tick();
        issue(0, 4'd2, 8'hF0, 8'h3C);
        chk_rsp("and", 8'h30, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        issue(0, 4'd3, 8'hF0, 8'h0F);
        chk_rsp("or", 8'hFF, 1'b0, 1'b0, 1'b1, 2'd0);
        tick();
        issue(0, 4'd1, 8'h05, 8'h03);
        chk_rsp("sub_nb", 8'h02, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk("final.busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
